// File: rtl/nios_accelerometer_pio_pkg.sv
// Shared constants for the Nios II key/switch input PIO: register map and edge-select codes.
package nios_accelerometer_pio_pkg;

    typedef enum logic [1:0] {
        ADDR_DATA     = 2'd0,
        ADDR_RESERVED = 2'd1,
        ADDR_IRQMASK  = 2'd2,
        ADDR_EDGECAP  = 2'd3
    } pio_addr_e;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    // Debounce counter width; a single-cycle debounce still needs one bit.
    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/nios_accelerometer_key_pio_if.sv
// Avalon-MM slave bus bundle shared by the key PIO and its bus master.
interface nios_accelerometer_key_pio_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/nios_accelerometer_key_pio_key_debounce.sv
// One input bit: two-flop synchroniser, stability counter, debounced value and its one-cycle delay.
module key_debounce
    import nios_accelerometer_pio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic deb,
    output logic deb_d
);
    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // NOTE: every register here is assigned with <= so all flops sample the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            // Preloading the whole chain from the pin means reset release never looks like an edge.
            sync1 <= raw;
            sync2 <= raw;
            deb   <= raw;
            deb_d <= raw;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_d <= deb;
            if (sync2 != deb) begin
                if (cnt == CNT_LAST) begin
                    deb <= sync2;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

// File: rtl/nios_accelerometer_key_pio.sv
// Avalon-MM input PIO for keys/switches: debounced data, edge capture (W1C), irq mask and level irq.
module nios_accelerometer_key_pio
    import nios_accelerometer_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = EDGE_FALLING
) (
    input  logic                         clk,
    input  logic                         reset,
    nios_accelerometer_key_pio_if.slave  bus,
    input  logic [WIDTH-1:0]             in_port,
    output logic                         irq
);
    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] deb_d;
    logic [WIDTH-1:0] edge_evt;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] cap_clr;
    logic             wr_en;
    logic             unused_wdata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
            .clk   (clk),
            .reset (reset),
            .raw   (in_port[i]),
            .deb   (deb[i]),
            .deb_d (deb_d[i])
        );
    end

    always_comb begin
        if (EDGE_TYPE == EDGE_RISING)       edge_evt = deb & ~deb_d;
        else if (EDGE_TYPE == EDGE_FALLING) edge_evt = ~deb & deb_d;
        else                                edge_evt = deb ^ deb_d;
    end

    assign wr_en        = bus.chipselect & ~bus.write_n;
    assign cap_clr      = (wr_en && bus.address == ADDR_EDGECAP) ? bus.writedata[WIDTH-1:0] : '0;
    assign unused_wdata = ^bus.writedata;

    always_ff @(posedge clk) begin
        if (reset) begin
            irqmask     <= '0;
            edgecapture <= '0;
            irq         <= 1'b0;
        end else begin
            if (wr_en && bus.address == ADDR_IRQMASK)
                irqmask <= bus.writedata[WIDTH-1:0];
            // Set is OR-ed in after the clear so a coincident edge is never lost.
            edgecapture <= (edgecapture & ~cap_clr) | edge_evt;
            irq         <= |(edgecapture & irqmask);
        end
    end

    // NOTE: readdata gets a full default before the case, so no latch is inferred for any address.
    always_comb begin
        bus.readdata = '0;
        unique case (pio_addr_e'(bus.address))
            ADDR_DATA:     bus.readdata[WIDTH-1:0] = deb;
            ADDR_RESERVED: bus.readdata = '0;
            ADDR_IRQMASK:  bus.readdata[WIDTH-1:0] = irqmask;
            ADDR_EDGECAP:  bus.readdata[WIDTH-1:0] = edgecapture;
        endcase
    end
endmodule

// File: tb/tb_nios_accelerometer_key_pio.sv
// Directed plus randomized bench for the key PIO, checked against a cycle-level behavioural model.
module tb_nios_accelerometer_key_pio;
    import nios_accelerometer_pio_pkg::*;

    localparam int W   = 4;
    localparam int DEB = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] in_port;
    logic         irq;

    nios_accelerometer_key_pio_if bus_if ();

    nios_accelerometer_key_pio #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (DEB),
        .EDGE_TYPE       (EDGE_FALLING)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus_if),
        .in_port (in_port),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: pin seen two samples late, debounced value follows after DEB mismatching samples.
    logic [W-1:0] m_pin_q1, m_pin_q2;
    logic [W-1:0] m_deb, m_deb_prev, m_cap, m_mask;
    logic         m_irq;
    int           m_run [W];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [1:0] a);
        case (a)
            2'd0:    return 32'(m_deb);
            2'd2:    return 32'(m_mask);
            2'd3:    return 32'(m_cap);
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_edge();
        logic         wr;
        logic [W-1:0] wd, clr, falls, new_mask;
        logic         new_irq;
        if (reset) begin
            m_pin_q1 = in_port; m_pin_q2 = in_port;
            m_deb = in_port; m_deb_prev = in_port;
            m_cap = '0; m_mask = '0; m_irq = 1'b0;
            for (int i = 0; i < W; i++) m_run[i] = 0;
            return;
        end
        wr       = bus_if.chipselect && !bus_if.write_n;
        wd       = bus_if.writedata[W-1:0];
        clr      = (wr && bus_if.address == 2'd3) ? wd : '0;
        new_mask = (wr && bus_if.address == 2'd2) ? wd : m_mask;
        new_irq  = |(m_cap & m_mask);
        falls    = m_deb_prev & ~m_deb;
        m_cap    = (m_cap & ~clr) | falls;
        m_deb_prev = m_deb;
        for (int i = 0; i < W; i++) begin
            if (m_pin_q2[i] != m_deb[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_deb[i] = m_pin_q2[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_pin_q2 = m_pin_q1;
        m_pin_q1 = in_port;
        m_mask   = new_mask;
        m_irq    = new_irq;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b0;
        bus_if.address    = a;
        bus_if.writedata  = d;
        tick();
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus_if.address = a;
        #1;
        d = bus_if.readdata;
    endtask

    task automatic check_model(input string tag, input logic [1:0] a);
        logic [31:0] d;
        rd(a, d);
        check({tag, "_rd"}, d, model_rd(a));
        check({tag, "_irq"}, 32'(irq), 32'(m_irq));
    endtask

    initial begin
        logic [31:0] d;
        reset = 1'b1;
        in_port = 4'hF;
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        bus_if.address    = 2'd0;
        bus_if.writedata  = 32'h0;
        repeat (3) tick();
        reset = 1'b0;
        repeat (20) tick();
        rd(2'd0, d); check("reset_data", d, 32'h0000000F);
        rd(2'd3, d); check("reset_edgecap", d, 32'h0);
        check("reset_irq", 32'(irq), 32'h0);

        // Falling edge on bit 0 reaches data after 6 cycles, capture one cycle later.
        in_port[0] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 5) begin rd(2'd0, d); check("deb_not_yet", d, 32'hF); end
            if (k == 6) begin
                rd(2'd0, d); check("deb_at_6", d, 32'hE);
                rd(2'd3, d); check("cap_not_yet", d, 32'h0);
            end
            if (k == 7) begin rd(2'd3, d); check("cap_at_7", d, 32'h1); end
            check_model("fall0", 2'd0);
        end

        bus_write(2'd2, 32'h1);
        check("irq_lag_mask", 32'(irq), 32'h0);
        tick();
        check("irq_set", 32'(irq), 32'h1);
        bus_write(2'd3, 32'h1);
        rd(2'd3, d); check("cap_cleared", d, 32'h0);
        check("irq_lag_clear", 32'(irq), 32'h1);
        tick();
        check("irq_cleared", 32'(irq), 32'h0);

        // Bouncing bit 1: never low long enough to register.
        for (int i = 0; i < 30; i++) begin
            in_port[1] = (i % 3 == 2);
            tick();
            rd(2'd0, d); check("bounce_deb1", 32'(d[1]), 32'h1);
        end
        in_port[1] = 1'b1;
        repeat (8) tick();
        rd(2'd3, d); check("bounce_cap1", 32'(d[1]), 32'h0);
        check_model("bounce", 2'd0);

        // Bit 2 edge captured in the same cycle as a W1C write to bit 2.
        in_port[2] = 1'b0;
        repeat (6) tick();
        rd(2'd0, d); check("b2_deb", d, 32'hA);
        rd(2'd3, d); check("b2_cap_pre", d, 32'h0);
        bus_write(2'd3, 32'h4);
        rd(2'd3, d); check("set_beats_clear", d, 32'h4);
        bus_write(2'd3, 32'h4);
        rd(2'd3, d); check("b2_cap_clr", d, 32'h0);
        check_model("b2", 2'd3);

        // Reset mid-debounce on bit 3.
        bus_write(2'd2, 32'hF);
        in_port[3] = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd(2'd0, d); check("rst_mid_data", d, 32'h2);
        rd(2'd3, d); check("rst_mid_cap", d, 32'h0);
        rd(2'd2, d); check("rst_mid_mask", d, 32'h0);
        check("rst_mid_irq", 32'(irq), 32'h0);
        for (int i = 0; i < 10; i++) begin
            tick();
            rd(2'd3, d); check("rst_no_edge", d, 32'h0);
            check("rst_no_irq", 32'(irq), 32'h0);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(7) == 0) in_port = W'($urandom);
            if ($urandom_range(4) == 0)
                bus_write(2'($urandom_range(3)), $urandom);
            else
                tick();
            check_model("rand", 2'($urandom_range(3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
